clk_src_sequencer: RTL and testbench

//  Always-on sequencer driving the rcc_cr select of the three-way glitch-free clock switch.

---
 rtl/clk_src_sequencer_if.sv | 26 ++
 rtl/clk_src_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_clk_src_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_src_sequencer_if.sv
// Request/status bundle between the software-facing side (requester plus
// oscillator/PLL status) and clk_src_sequencer. The sequencer takes the
// slave view; whoever issues requests and reports ready takes the master view.
interface clk_src_sequencer_if;
    logic       sw_req;       // one-cycle request pulse
    logic [1:0] sw_sel;       // 00=10M, 01=32K, 10=100M, 11=illegal
    logic       rdy_10M;      // asynchronous 10M oscillator ready
    logic       lock_100M;    // asynchronous 100M PLL lock
    logic       osc_en_10M;   // 10M oscillator enable
    logic       pll_en_100M;  // 100M PLL enable
    logic [1:0] rcc_cr;       // select to the glitch-free clock switch
    logic       sw_busy;      // sequence in progress
    logic       sw_done;      // one-cycle completion pulse
    logic       sw_err;       // one-cycle rejection/abort pulse
    logic [1:0] err_code;     // 01=illegal select, 10=ready timeout

    modport master (
        output sw_req, sw_sel, rdy_10M, lock_100M,
        input  osc_en_10M, pll_en_100M, rcc_cr, sw_busy, sw_done, sw_err, err_code
    );

    modport slave (
        input  sw_req, sw_sel, rdy_10M, lock_100M,
        output osc_en_10M, pll_en_100M, rcc_cr, sw_busy, sw_done, sw_err, err_code
    );
endinterface

// File: rtl/clk_src_sequencer.sv
// clk_src_sequencer: always-on sequencer for the three-way glitch-free clock
// switch. Enables the requested oscillator/PLL, waits for its synchronised
// ready, waits a settle time, drives rcc_cr, then holds off while the switch
// hands over. Runs on the never-gated 32 kHz clock.
// Optional feature: define CLK_SEQ_AUTO_OFF_EN to switch the previous source
// off after the handover (extra OFF_OLD state, sw_done one cycle later).
module clk_src_sequencer #(
    parameter int unsigned RDY_TIMEOUT = 64,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk_32K,
    input  logic                rst,
    clk_src_sequencer_if.slave  bus
);

    localparam logic [1:0] SEL_10M  = 2'b00;
    localparam logic [1:0] SEL_32K  = 2'b01;
    localparam logic [1:0] SEL_100M = 2'b10;
    localparam logic [1:0] SEL_ILL  = 2'b11;

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(RDY_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EN_SRC   = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_SETTLE   = 3'd3,
        S_SWITCH   = 3'd4,
        S_HOLD     = 3'd5
`ifdef CLK_SEQ_AUTO_OFF_EN
        , S_OFF_OLD = 3'd6
`endif
    } state_t;

    // Ready of a source: 32K is always running, 11 never becomes ready.
    function automatic logic src_ready(input logic [1:0] sel,
                                       input logic       rdy_10m,
                                       input logic       lock_100m);
        logic rdy;
        case (sel)
            SEL_10M:  rdy = rdy_10m;
            SEL_32K:  rdy = 1'b1;
            SEL_100M: rdy = lock_100m;
            default:  rdy = 1'b0;
        endcase
        return rdy;
    endfunction

    // Enable vector is {10M, 100M}; returns it with the enable of 'sel'
    // forced to 'val'. 32K has no enable, so it leaves the vector untouched.
    function automatic logic [1:0] set_enable(input logic [1:0] en,
                                              input logic [1:0] sel,
                                              input logic       val);
        logic [1:0] res;
        res = en;
        case (sel)
            SEL_10M:  res[1] = val;
            SEL_100M: res[0] = val;
            default:  res = en;
        endcase
        return res;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       tgt_q, tgt_d;
    logic [1:0]       old_q, old_d;
    logic [1:0]       rcc_q, rcc_d;
    logic [1:0]       en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic             rdy10_meta_q, rdy10_sync_q;
    logic             lock_meta_q, lock_sync_q;
    logic             tgt_rdy_s;

    // Two-flop synchronisers for the asynchronous ready/lock inputs.
    always_ff @(posedge clk_32K or posedge rst) begin
        if (rst) begin
            rdy10_meta_q <= 1'b0;
            rdy10_sync_q <= 1'b0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
        end else begin
            rdy10_meta_q <= bus.rdy_10M;
            rdy10_sync_q <= rdy10_meta_q;
            lock_meta_q  <= bus.lock_100M;
            lock_sync_q  <= lock_meta_q;
        end
    end

    assign tgt_rdy_s = src_ready(tgt_q, rdy10_sync_q, lock_sync_q);

    // Next-state and next-output logic of the switch sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        old_d   = old_q;
        rcc_d   = rcc_q;
        en_d    = en_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;

        case (state_q)
            S_IDLE: begin
                if (bus.sw_req) begin
                    tgt_d = bus.sw_sel;
                    old_d = rcc_q;
                    if (bus.sw_sel == SEL_ILL) begin
                        err_d  = 1'b1;
                        code_d = ERR_ILLEGAL;
                    end else if (bus.sw_sel == rcc_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_EN_SRC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EN_SRC: begin
                en_d    = set_enable(en_q, tgt_q, 1'b1);
                cnt_d   = TIMEOUT_LD;
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (tgt_rdy_s) begin
                    cnt_d   = SETTLE_LD;
                    state_d = S_SETTLE;
                end else if (cnt_q == CNT_ZERO) begin
                    // Abort: only switch off the target, never the running source.
                    if (tgt_q != old_q) begin
                        en_d = set_enable(en_q, tgt_q, 1'b0);
                    end else begin
                        en_d = en_q;
                    end
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_SWITCH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SWITCH: begin
                rcc_d   = tgt_q;
                cnt_d   = HOLD_LD;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
`ifdef CLK_SEQ_AUTO_OFF_EN
                    state_d = S_OFF_OLD;
`else
                    done_d  = 1'b1;
                    state_d = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef CLK_SEQ_AUTO_OFF_EN
            S_OFF_OLD: begin
                // The previous source is no longer selected; never touch the live one.
                if (old_q != rcc_q) begin
                    en_d = set_enable(en_q, old_q, 1'b0);
                end else begin
                    en_d = en_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_32K or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            tgt_q   <= SEL_10M;
            old_q   <= SEL_10M;
            rcc_q   <= SEL_10M;
            en_q    <= 2'b10;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            old_q   <= old_d;
            rcc_q   <= rcc_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bus.rcc_cr      = rcc_q;
    assign bus.osc_en_10M  = en_q[1];
    assign bus.pll_en_100M = en_q[0];
    assign bus.sw_busy     = busy_q;
    assign bus.sw_done     = done_q;
    assign bus.sw_err      = err_q;
    assign bus.err_code    = code_q;

endmodule

// File: tb/tb_clk_src_sequencer.sv
// Self-checking bench for clk_src_sequencer. A request-level model predicts,
// per request, the edge at which each output event happens and the source /
// enable state afterwards; directed and randomised scenarios compare the DUT
// against it. Edge 1 is the clock edge that samples sw_req.
module tb_clk_src_sequencer;

    localparam int RDY_TIMEOUT = 64;
    localparam int SETTLE_CYC  = 4;
    localparam int HOLD_CYC    = 8;
`ifdef CLK_SEQ_AUTO_OFF_EN
    localparam int AUTO_OFF = 1;
`else
    localparam int AUTO_OFF = 0;
`endif
    // {rcc_cr, osc_en_10M, pll_en_100M, sw_busy, sw_done, sw_err, err_code}
    localparam logic [8:0] RST_VEC = 9'b00_1_0_0_0_0_00;

    logic clk_32K;
    logic rst;
    int   n_tests;
    int   n_fail;

    // Model state.
    logic [1:0] m_rcc;
    logic       m_en10;
    logic       m_en100;
    logic [1:0] m_code;

    // Expectations for the current request (-1 = event must not happen).
    bit         x_need_rdy;
    int         x_done;
    int         x_err;
    int         x_rcc;
    int         x_en;
    logic [1:0] x_code;

    // Observations for the current request.
    int         o_done_at, o_done_cnt, o_err_at, o_err_cnt;
    int         o_rcc_at, o_rcc_chg, o_en_at;
    logic [1:0] o_code;
    bit         o_busy, o_bad_rcc, o_busy_pre;
    logic [8:0] o_snap;

    clk_src_sequencer_if bus ();

    clk_src_sequencer #(
        .RDY_TIMEOUT (RDY_TIMEOUT),
        .SETTLE_CYC  (SETTLE_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .CNT_W       (8)
    ) dut (
        .clk_32K (clk_32K),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk_32K = 1'b0;
    always #5 clk_32K = ~clk_32K;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [8:0] out_vec();
        return {bus.rcc_cr, bus.osc_en_10M, bus.pll_en_100M, bus.sw_busy,
                bus.sw_done, bus.sw_err, bus.err_code};
    endfunction

    task automatic model_reset();
        m_rcc = 2'b00; m_en10 = 1'b1; m_en100 = 1'b0; m_code = 2'b00;
    endtask

    // Request-level model. d = cycles after the target enable is observed
    // until the bench raises its ready (-1: never). Ready passes two sync
    // flops (edges 3+d, 4+d) and is acted on at the following edge; the
    // wait state spans edges 3 .. 2+RDY_TIMEOUT. After ready: SETTLE_CYC
    // settle edges, one switch edge (rcc_cr moves), HOLD_CYC hold edges,
    // plus one more edge when the old source is switched off.
    task automatic model_req(input logic [1:0] sel, input int d);
        int e_det;
        logic [1:0] old;
        x_need_rdy = 1'b0; x_done = -1; x_err = -1; x_rcc = -1; x_en = -1; x_code = m_code;
        if (sel == 2'b11) begin
            x_err = 1; x_code = 2'b01; m_code = 2'b01;
        end else if (sel == m_rcc) begin
            x_done = 1;
        end else begin
            x_need_rdy = (sel != 2'b01);
            if (sel == 2'b00) begin x_en = m_en10 ? 1 : 2;  m_en10 = 1'b1;  end
            if (sel == 2'b10) begin x_en = m_en100 ? 1 : 2; m_en100 = 1'b1; end
            if (sel == 2'b01) e_det = 3;
            else if (d >= 0 && 5 + d <= 2 + RDY_TIMEOUT) e_det = 5 + d;
            else e_det = -1;
            if (e_det < 0) begin
                x_err = 2 + RDY_TIMEOUT; x_code = 2'b10; m_code = 2'b10;
                if (sel == 2'b00) m_en10 = 1'b0;
                if (sel == 2'b10) m_en100 = 1'b0;
            end else begin
                x_rcc  = e_det + SETTLE_CYC + 1;
                x_done = x_rcc + HOLD_CYC + AUTO_OFF;
                old    = m_rcc;
                m_rcc  = sel;
                if (AUTO_OFF != 0 && old == 2'b00) m_en10 = 1'b0;
                if (AUTO_OFF != 0 && old == 2'b10) m_en100 = 1'b0;
            end
        end
    endtask

    // Issue one request and record when each output event is seen.
    task automatic run_req(input logic [1:0] sel, input int d, input int req2_at,
                           input logic [1:0] sel2, input int rst_at);
        logic [1:0] prev_rcc;
        logic       en_now;
        int         end_e;
        o_done_at = -1; o_done_cnt = 0; o_err_at = -1; o_err_cnt = 0; o_rcc_at = -1;
        o_rcc_chg = 0; o_en_at = -1; o_code = 2'b00; o_busy = 1'b0; o_bad_rcc = 1'b0;
        o_busy_pre = 1'b0; o_snap = 9'b0;
        end_e = -1;
        if (x_need_rdy) begin
            if (sel == 2'b00) bus.rdy_10M = 1'b0; else bus.lock_100M = 1'b0;
        end
        prev_rcc = bus.rcc_cr;
        bus.sw_sel = sel;
        bus.sw_req = 1'b1;
        for (int e = 1; e <= 120; e++) begin
            @(posedge clk_32K);
            @(negedge clk_32K);
            bus.sw_req = 1'b0;
            if (e == req2_at) begin bus.sw_sel = sel2; bus.sw_req = 1'b1; end
            if (x_need_rdy && d >= 0 && e == 2 + d) begin
                if (sel == 2'b00) bus.rdy_10M = 1'b1; else bus.lock_100M = 1'b1;
            end
            if (bus.sw_done === 1'b1) begin o_done_cnt++; if (o_done_at < 0) o_done_at = e; end
            if (bus.sw_err === 1'b1) begin
                o_err_cnt++;
                if (o_err_at < 0) begin o_err_at = e; o_code = bus.err_code; end
            end
            if (bus.sw_busy === 1'b1) o_busy = 1'b1;
            if (bus.rcc_cr !== prev_rcc) begin
                o_rcc_chg++; if (o_rcc_at < 0) o_rcc_at = e; prev_rcc = bus.rcc_cr;
            end
            if (bus.rcc_cr === 2'b11) o_bad_rcc = 1'b1;
            en_now = (sel == 2'b00) ? bus.osc_en_10M : (sel == 2'b10) ? bus.pll_en_100M : 1'b0;
            if (en_now === 1'b1 && o_en_at < 0) o_en_at = e;
            if (e == rst_at) begin
                o_busy_pre = bus.sw_busy;
                rst = 1'b1;
                #1;
                o_snap = out_vec();
                @(negedge clk_32K);
                rst = 1'b0;
                break;
            end
            if (end_e < 0 && (o_done_at >= 0 || o_err_at >= 0)) end_e = e;
            if (end_e >= 0 && e >= end_e + 3) break;
        end
        bus.sw_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sw_req = 1'b0; bus.sw_sel = 2'b00; bus.rdy_10M = 1'b1; bus.lock_100M = 1'b0;
        repeat (3) @(negedge clk_32K);
        n_tests++; if (out_vec() !== RST_VEC) begin n_fail++; $display("FAIL reset_values: got %b want %b", out_vec(), RST_VEC); end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_32K);
            n_tests++; if (out_vec() !== RST_VEC) begin n_fail++; $display("FAIL reset_hold cycle %0d: got %b want %b", i, out_vec(), RST_VEC); end
        end
    endtask

    task automatic test_illegal();
        model_req(2'b11, 0);
        run_req(2'b11, 0, -1, 2'b00, -1);
        n_tests++; if (o_err_at !== x_err) begin n_fail++; $display("FAIL illegal_err_edge: got %0d want %0d", o_err_at, x_err); end
        n_tests++; if (o_code !== 2'b01) begin n_fail++; $display("FAIL illegal_code: got %b want 01", o_code); end
        n_tests++; if (o_err_cnt !== 1) begin n_fail++; $display("FAIL illegal_err_width: got %0d want 1", o_err_cnt); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL illegal_busy: got %b want 0", o_busy); end
        n_tests++; if (o_done_cnt !== 0) begin n_fail++; $display("FAIL illegal_done: got %0d want 0", o_done_cnt); end
    endtask

    task automatic test_timeout();
        model_req(2'b10, -1);
        run_req(2'b10, -1, -1, 2'b00, -1);
        n_tests++; if (o_en_at !== x_en) begin n_fail++; $display("FAIL timeout_pll_on: got %0d want %0d", o_en_at, x_en); end
        n_tests++; if (o_err_at !== x_err) begin n_fail++; $display("FAIL timeout_err_edge: got %0d want %0d", o_err_at, x_err); end
        n_tests++; if (o_code !== 2'b10) begin n_fail++; $display("FAIL timeout_code: got %b want 10", o_code); end
        n_tests++; if (o_rcc_chg !== 0) begin n_fail++; $display("FAIL timeout_rcc_changes: got %0d want 0", o_rcc_chg); end
        n_tests++; if (bus.pll_en_100M !== 1'b0) begin n_fail++; $display("FAIL timeout_pll_off: got %b want 0", bus.pll_en_100M); end
        n_tests++; if (out_vec() !== {m_rcc, m_en10, m_en100, 3'b000, m_code}) begin n_fail++; $display("FAIL timeout_final: got %b want %b", out_vec(), {m_rcc, m_en10, m_en100, 3'b000, m_code}); end
    endtask

    task automatic test_switch_100m();
        model_req(2'b10, 10);
        run_req(2'b10, 10, -1, 2'b00, -1);
        n_tests++; if (o_en_at !== x_en) begin n_fail++; $display("FAIL sw100_pll_on: got %0d want %0d", o_en_at, x_en); end
        n_tests++; if (o_rcc_at !== x_rcc) begin n_fail++; $display("FAIL sw100_rcc_edge: got %0d want %0d", o_rcc_at, x_rcc); end
        n_tests++; if (o_done_at !== x_done) begin n_fail++; $display("FAIL sw100_done_edge: got %0d want %0d", o_done_at, x_done); end
        n_tests++; if (o_done_cnt !== 1) begin n_fail++; $display("FAIL sw100_done_width: got %0d want 1", o_done_cnt); end
        n_tests++; if (o_rcc_chg !== 1) begin n_fail++; $display("FAIL sw100_rcc_changes: got %0d want 1", o_rcc_chg); end
        n_tests++; if (out_vec() !== {m_rcc, m_en10, m_en100, 3'b000, m_code}) begin n_fail++; $display("FAIL sw100_final: got %b want %b", out_vec(), {m_rcc, m_en10, m_en100, 3'b000, m_code}); end
    endtask

    task automatic test_ignore_busy();
        model_req(2'b01, 0);
        run_req(2'b01, 0, x_rcc + 3, 2'b00, -1);
        n_tests++; if (o_rcc_at !== x_rcc) begin n_fail++; $display("FAIL ignore_rcc_edge: got %0d want %0d", o_rcc_at, x_rcc); end
        n_tests++; if (o_done_at !== x_done) begin n_fail++; $display("FAIL ignore_done_edge: got %0d want %0d", o_done_at, x_done); end
        n_tests++; if (o_done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", o_done_cnt); end
        n_tests++; if (bus.rcc_cr !== 2'b01) begin n_fail++; $display("FAIL ignore_rcc_final: got %b want 01", bus.rcc_cr); end
        n_tests++; if (bus.pll_en_100M !== (AUTO_OFF == 0)) begin n_fail++; $display("FAIL ignore_pll_en: got %b want %b", bus.pll_en_100M, (AUTO_OFF == 0)); end
        n_tests++; if (out_vec() !== {m_rcc, m_en10, m_en100, 3'b000, m_code}) begin n_fail++; $display("FAIL ignore_final: got %b want %b", out_vec(), {m_rcc, m_en10, m_en100, 3'b000, m_code}); end
    endtask

    task automatic test_same_src();
        model_req(2'b01, 0);
        run_req(2'b01, 0, -1, 2'b00, -1);
        n_tests++; if (o_done_at !== x_done) begin n_fail++; $display("FAIL same_done_edge: got %0d want %0d", o_done_at, x_done); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL same_busy: got %b want 0", o_busy); end
        n_tests++; if (out_vec() !== {m_rcc, m_en10, m_en100, 3'b000, m_code}) begin n_fail++; $display("FAIL same_final: got %b want %b", out_vec(), {m_rcc, m_en10, m_en100, 3'b000, m_code}); end
    endtask

    task automatic test_reset_mid();
        int d;
        d = int'($urandom_range(0, 20));
        model_req(2'b00, d);
        run_req(2'b00, d, -1, 2'b00, -1);
        n_tests++; if (o_done_at !== x_done) begin n_fail++; $display("FAIL rstmid_to10m_done: got %0d want %0d", o_done_at, x_done); end
        // 00 -> 10 with lock 3 cycles late; reset two edges into SETTLE.
        model_req(2'b10, 3);
        run_req(2'b10, 3, -1, 2'b00, x_rcc - SETTLE_CYC + 1);
        n_tests++; if (o_busy_pre !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", o_busy_pre); end
        n_tests++; if (o_snap !== RST_VEC) begin n_fail++; $display("FAIL rstmid_async_values: got %b want %b", o_snap, RST_VEC); end
        model_reset();
        n_tests++; if (out_vec() !== RST_VEC) begin n_fail++; $display("FAIL rstmid_after_release: got %b want %b", out_vec(), RST_VEC); end
        d = int'($urandom_range(0, 20));
        model_req(2'b10, d);
        run_req(2'b10, d, -1, 2'b00, -1);
        n_tests++; if (o_rcc_at !== x_rcc) begin n_fail++; $display("FAIL rstmid_retry_rcc: got %0d want %0d", o_rcc_at, x_rcc); end
        n_tests++; if (o_done_at !== x_done) begin n_fail++; $display("FAIL rstmid_retry_done: got %0d want %0d", o_done_at, x_done); end
        n_tests++; if (out_vec() !== {m_rcc, m_en10, m_en100, 3'b000, m_code}) begin n_fail++; $display("FAIL rstmid_retry_final: got %b want %b", out_vec(), {m_rcc, m_en10, m_en100, 3'b000, m_code}); end
    endtask

    task automatic test_random();
        logic [1:0] sel, sel2;
        int d, r, req2, last;
        for (int it = 0; it < 30; it++) begin
            sel = 2'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            d = (r == 0) ? 61 : (r == 1) ? 62 : (r == 2) ? -1 : int'($urandom_range(0, 30));
            model_req(sel, d);
            last = (x_done >= 0) ? x_done : x_err;
            req2 = -1;
            sel2 = 2'($urandom_range(0, 3));
            if (last > 1 && $urandom_range(0, 1) == 1) req2 = int'($urandom_range(1, last - 1));
            run_req(sel, d, req2, sel2, -1);
            n_tests++; if (o_done_at !== x_done || o_done_cnt !== (x_done >= 0 ? 1 : 0)) begin n_fail++; $display("FAIL rand%0d_done: sel=%b d=%0d got edge %0d x%0d want edge %0d", it, sel, d, o_done_at, o_done_cnt, x_done); end
            n_tests++; if (o_err_at !== x_err || o_err_cnt !== (x_err >= 0 ? 1 : 0)) begin n_fail++; $display("FAIL rand%0d_err: sel=%b d=%0d got edge %0d x%0d want edge %0d", it, sel, d, o_err_at, o_err_cnt, x_err); end
            n_tests++; if (o_rcc_at !== x_rcc || o_rcc_chg !== (x_rcc >= 0 ? 1 : 0) || o_bad_rcc) begin n_fail++; $display("FAIL rand%0d_rcc: sel=%b d=%0d got edge %0d changes %0d want edge %0d", it, sel, d, o_rcc_at, o_rcc_chg, x_rcc); end
            n_tests++; if (x_en >= 0 && o_en_at !== x_en) begin n_fail++; $display("FAIL rand%0d_enable: sel=%b got edge %0d want %0d", it, sel, o_en_at, x_en); end
            n_tests++; if (out_vec() !== {m_rcc, m_en10, m_en100, 3'b000, m_code}) begin n_fail++; $display("FAIL rand%0d_final: sel=%b d=%0d got %b want %b", it, sel, d, out_vec(), {m_rcc, m_en10, m_en100, 3'b000, m_code}); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_illegal();
        test_timeout();
        test_switch_100m();
        test_ignore_busy();
        test_same_src();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
